// File: rtl/amo_initiator.sv
// Core-side initiator for the TCDM bank protocol: one load/store/AMO in flight at a time,
// lane placement of 32-bit requests onto the bank word and realignment of read data.
module amo_initiator #(
   parameter int unsigned AddrMemWidth = 32,
   parameter int unsigned DataWidth    = 64
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic [AddrMemWidth-1:0]   req_addr_i,
   input  logic                      req_upper_i,
   input  logic [3:0]                req_amo_i,
   input  logic                      req_wen_i,
   input  logic [31:0]               req_wdata_i,
   input  logic [31:0]               req_swap_i,
   input  logic [3:0]                req_be_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [31:0]               rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      out_req_o,
   input  logic                      out_gnt_i,
   output logic [AddrMemWidth-1:0]   out_add_o,
   output logic [3:0]                out_amo_o,
   output logic                      out_wen_o,
   output logic [DataWidth-1:0]      out_wdata_o,
   output logic [DataWidth/8-1:0]    out_be_o,
   input  logic [DataWidth-1:0]      out_rdata_i
);

   localparam int unsigned BeWidth = DataWidth / 8;
   localparam logic [3:0]  AmoNone = 4'h0;
   localparam logic [3:0]  AmoCas  = 4'hA;

   typedef enum logic [1:0] {StIdle, StReq, StWait, StRsp} state_e;

   state_e                  r_state;
   logic                    r_req_ready;
   logic                    r_out_req;
   logic                    r_rsp_valid;
   logic                    r_err;
   logic [AddrMemWidth-1:0] r_add;
   logic [3:0]              r_amo;
   logic                    r_wen;
   logic                    r_upper;
   logic [DataWidth-1:0]    r_wdata;
   logic [BeWidth-1:0]      r_be;
   logic [31:0]             r_rdata;

   logic                    w_upper;
   logic                    w_is_store;
   logic                    w_illegal;
   logic [3:0]              w_be4;
   logic [DataWidth-1:0]    w_wdata;
   logic [BeWidth-1:0]      w_be;
   logic [31:0]             w_lane;

   assign w_upper    = (DataWidth == 64) && req_upper_i;
   assign w_is_store = (req_amo_i == AmoNone) && req_wen_i;
   assign w_be4      = w_is_store ? req_be_i : 4'hF;
   assign w_illegal  = (req_amo_i > AmoCas) ||
                       ((req_amo_i == AmoCas) && ((DataWidth == 32) || req_upper_i));

   if (DataWidth == 64) begin : g_dw64
      // Replicated operand lets the shim pick either lane; CAS packs swap above compare.
      assign w_wdata = (req_amo_i == AmoCas) ? {req_swap_i, req_wdata_i}
                                             : {req_wdata_i, req_wdata_i};
      assign w_be    = w_upper ? {w_be4, 4'h0} : {4'h0, w_be4};
      assign w_lane  = r_upper ? out_rdata_i[63:32] : out_rdata_i[31:0];
   end else if (DataWidth == 32) begin : g_dw32
      assign w_wdata = req_wdata_i;
      assign w_be    = w_be4;
      assign w_lane  = out_rdata_i[31:0];
   end else begin : g_bad
      $fatal(1, "amo_initiator: DataWidth must be 32 or 64");
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= StIdle;
         r_req_ready <= 1'b1;
         r_out_req   <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_err       <= 1'b0;
         r_add       <= '0;
         r_amo       <= '0;
         r_wen       <= 1'b0;
         r_upper     <= 1'b0;
         r_wdata     <= '0;
         r_be        <= '0;
         r_rdata     <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (req_valid_i) begin
                  r_add       <= req_addr_i;
                  r_amo       <= req_amo_i;
                  r_wen       <= w_is_store;
                  r_upper     <= w_upper;
                  r_wdata     <= w_wdata;
                  r_be        <= w_be;
                  r_rdata     <= '0;
                  r_req_ready <= 1'b0;
                  if (w_illegal) begin
                     r_err       <= 1'b1;
                     r_rsp_valid <= 1'b1;
                     r_state     <= StRsp;
                  end else begin
                     r_out_req <= 1'b1;
                     r_state   <= StReq;
                  end
               end
            end
            StReq: begin
               if (out_gnt_i) begin
                  r_out_req <= 1'b0;
                  r_state   <= StWait;
               end
            end
            StWait: begin
               r_rdata     <= r_wen ? 32'h0 : w_lane;
               r_rsp_valid <= 1'b1;
               r_state     <= StRsp;
            end
            StRsp: begin
               if (rsp_ready_i) begin
                  r_rsp_valid <= 1'b0;
                  r_err       <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign req_ready_o = r_req_ready;
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_rdata_o = r_rdata;
   assign rsp_err_o   = r_err;
   assign out_req_o   = r_out_req;
   assign out_add_o   = r_add;
   assign out_amo_o   = r_amo;
   assign out_wen_o   = r_wen;
   assign out_wdata_o = r_wdata;
   assign out_be_o    = r_be;

endmodule
